// File: rtl/reg5_write_arbiter.sv
// Round-robin write arbiter for a shared 5-bit clock-enabled register.
// It issues one-cycle Ce/Din commits, gives clear absolute priority, and enforces a programmable gap.
module reg5_write_arbiter #(
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  req,
    input  logic [19:0] din,
    input  logic        clr,
    output logic        reg_ce,
    output logic [4:0]  reg_din,
    output logic [3:0]  ack,
    output logic [1:0]  last_id,
    output logic        busy,
    output logic [7:0]  commit_cnt
);

    typedef enum logic [1:0] {StIdle, StCommit, StGap} state_t;

    localparam logic [3:0] GapLoad = (HOLD_CYCLES > 0) ? 4'(HOLD_CYCLES - 1) : 4'd0;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_gap, w_gap_nxt;
    logic [1:0]  r_ptr;
    logic        r_ce, r_busy;
    logic [4:0]  r_din;
    logic [3:0]  r_ack;
    logic [1:0]  r_last;
    logic [7:0]  r_cnt;

    logic        w_found;
    logic [1:0]  w_gnt_id;
    logic [1:0]  w_idx;
    logic [4:0]  w_gnt_data;

    // First set request scanning upward from r_ptr, modulo 4.
    always_comb begin
        w_found  = 1'b0;
        w_gnt_id = r_ptr;
        w_idx    = r_ptr;
        for (int i = 0; i < 4; i++) begin
            w_idx = r_ptr + 2'(i);
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_gnt_id = w_idx;
            end
        end
    end

    always_comb begin
        w_gnt_data = din[4:0];
        unique case (w_gnt_id)
            2'd0: w_gnt_data = din[4:0];
            2'd1: w_gnt_data = din[9:5];
            2'd2: w_gnt_data = din[14:10];
            2'd3: w_gnt_data = din[19:15];
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap;
        case (r_state)
            StIdle: begin
                if (clr || w_found) w_state_nxt = StCommit;
            end
            StCommit: begin
                if (HOLD_CYCLES > 0) begin
                    w_state_nxt = StGap;
                    w_gap_nxt   = GapLoad;
                end else begin
                    w_state_nxt = StIdle;
                end
            end
            StGap: begin
                if (r_gap == 4'd0) w_state_nxt = StIdle;
                else               w_gap_nxt   = r_gap - 4'd1;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= StIdle;
            r_gap   <= 4'd0;
            r_ptr   <= 2'd0;
            r_ce    <= 1'b0;
            r_din   <= 5'd0;
            r_ack   <= 4'd0;
            r_last  <= 2'd0;
            r_busy  <= 1'b0;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_gap   <= w_gap_nxt;
            r_busy  <= (w_state_nxt != StIdle);
            r_ce    <= 1'b0;
            r_ack   <= 4'd0;
            // Commit outputs are launched on the edge that enters COMMIT.
            if (r_state == StIdle) begin
                if (clr) begin
                    r_ce  <= 1'b1;
                    r_din <= 5'd0;
                    r_cnt <= r_cnt + 8'd1;
                end else if (w_found) begin
                    r_ce   <= 1'b1;
                    r_din  <= w_gnt_data;
                    r_ack  <= 4'b0001 << w_gnt_id;
                    r_last <= w_gnt_id;
                    r_ptr  <= w_gnt_id + 2'd1;
                    r_cnt  <= r_cnt + 8'd1;
                end
            end
        end
    end

    assign reg_ce     = r_ce;
    assign reg_din    = r_din;
    assign ack        = r_ack;
    assign last_id    = r_last;
    assign busy       = r_busy;
    assign commit_cnt = r_cnt;

endmodule

// File: tb/tb_reg5_write_arbiter.sv
// Directed bench for reg5_write_arbiter: a HOLD_CYCLES=2 instance and a zero-gap instance.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_reg5_write_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [3:0]  req = 4'd0, req0 = 4'd0;
    logic [19:0] din = 20'd0, din0 = 20'd0;
    logic        clr = 1'b0, clr0 = 1'b0;

    logic        reg_ce, reg_ce0;
    logic [4:0]  reg_din, reg_din0;
    logic [3:0]  ack, ack0;
    logic [1:0]  last_id, last_id0;
    logic        busy, busy0;
    logic [7:0]  commit_cnt, commit_cnt0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    reg5_write_arbiter #(.HOLD_CYCLES(2)) dut (
        .CLK(CLK), .RST(RST), .req(req), .din(din), .clr(clr),
        .reg_ce(reg_ce), .reg_din(reg_din), .ack(ack), .last_id(last_id),
        .busy(busy), .commit_cnt(commit_cnt)
    );

    reg5_write_arbiter #(.HOLD_CYCLES(0)) dut0 (
        .CLK(CLK), .RST(RST), .req(req0), .din(din0), .clr(clr0),
        .reg_ce(reg_ce0), .reg_din(reg_din0), .ack(ack0), .last_id(last_id0),
        .busy(busy0), .commit_cnt(commit_cnt0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
    endtask

    // Waits at falling edges for reg_ce of the HOLD_CYCLES=2 instance, bounded.
    task automatic wait_ce(input int max_cycles, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < max_cycles && !seen; c++) begin
            @(negedge CLK);
            if (reg_ce) seen = 1'b1;
        end
    endtask

    initial begin
        bit seen;
        int n, prev, exp_id;

        // Reset with all requests up: everything stays zero.
        req = 4'b1111;
        @(negedge CLK);
        @(negedge CLK);
        check("rst_ce",   reg_ce,     0);
        check("rst_din",  reg_din,    0);
        check("rst_ack",  ack,        0);
        check("rst_last", last_id,    0);
        check("rst_busy", busy,       0);
        check("rst_cnt",  commit_cnt, 0);

        // First arbitration right after release.
        req = 4'b0001;
        din = 20'h00015;
        RST = 1'b1;
        @(negedge CLK);
        check("first_ce",   reg_ce,     1);
        check("first_din",  reg_din,    5'h15);
        check("first_ack",  ack,        4'b0001);
        check("first_busy", busy,       1);
        check("first_cnt",  commit_cnt, 1);
        req = 4'b0000;
        @(negedge CLK);
        check("gap_ce",   reg_ce,  0);
        check("gap_ack",  ack,     0);
        check("gap_hold", reg_din, 5'h15);
        check("gap_busy", busy,    1);
        @(negedge CLK);
        @(negedge CLK);
        check("idle_busy", busy, 0);

        // Round-robin with all four requesting, gap of 2.
        do_reset();
        din = {5'h13, 5'h12, 5'h11, 5'h10};
        req = 4'b1111;
        n = 0;
        prev = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (reg_ce) begin
                exp_id = n % 4;
                check("rr_ack",  ack,     4'b0001 << exp_id);
                check("rr_last", last_id, exp_id);
                check("rr_din",  reg_din, 5'h10 + exp_id);
                if (n > 0) check("rr_period", c - prev, 4);
                prev = c;
                n++;
            end
        end
        check("rr_commits", n, 5);
        req = 4'b0000;

        // Clear beats a simultaneous request; the request is served next.
        do_reset();
        din = 20'h0;
        din[14:10] = 5'h0A;
        clr = 1'b1;
        req = 4'b0100;
        @(negedge CLK);
        check("clr_ce",  reg_ce,     1);
        check("clr_din", reg_din,    0);
        check("clr_ack", ack,        0);
        check("clr_cnt", commit_cnt, 1);
        clr = 1'b0;
        wait_ce(10, seen);
        check("clr_next_seen", seen,       1);
        check("clr_next_ack",  ack,        4'b0100);
        check("clr_next_din",  reg_din,    5'h0A);
        check("clr_next_last", last_id,    2);
        check("clr_next_cnt",  commit_cnt, 2);
        req = 4'b0000;

        // Zero gap: requesters 1 and 3 alternate every 2 cycles.
        do_reset();
        din0 = {5'h1D, 5'h00, 5'h1B, 5'h00};
        req0 = 4'b1010;
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            check("zg_busy", busy0,   (c % 2 == 0));
            check("zg_ce",   reg_ce0, (c % 2 == 0));
            check("zg_ack",  ack0,    (c % 4 == 0) ? 4'b0010 : (c % 4 == 2) ? 4'b1000 : 4'b0000);
            check("zg_din",  reg_din0, (c % 4 < 2) ? 5'h1B : 5'h1D);
        end
        req0 = 4'b0000;

        // 256 clear commits wrap the counter without touching the pointer.
        do_reset();
        clr = 1'b1;
        n = 0;
        for (int c = 0; c < 1100 && n < 256; c++) begin
            @(negedge CLK);
            if (reg_ce) begin
                n++;
                if (n == 255) check("wrap_255", commit_cnt, 255);
            end
        end
        check("wrap_seen", n,          256);
        check("wrap_cnt",  commit_cnt, 0);
        check("wrap_ack",  ack,        0);
        clr = 1'b0;
        din = {5'h13, 5'h12, 5'h11, 5'h10};
        req = 4'b1111;
        wait_ce(10, seen);
        check("wrap_next_seen", seen,       1);
        check("wrap_next_ack",  ack,        4'b0001);
        check("wrap_next_cnt",  commit_cnt, 1);

        // Reset in the middle of a COMMIT cycle.
        wait_ce(10, seen);
        check("mid_seen", seen, 1);
        check("mid_ack",  ack,  4'b0010);
        RST = 1'b0;
        #1;
        check("mid_rst_ce",   reg_ce, 0);
        check("mid_rst_ack",  ack,    0);
        check("mid_rst_busy", busy,   0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("mid_regrant_ce",  reg_ce,  1);
        check("mid_regrant_ack", ack,     4'b0001);
        check("mid_regrant_din", reg_din, 5'h10);
        req = 4'b0000;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
